keypad_entry_ctrl: RTL

Sequencer between the 12-key keypad and the 8-digit display register file. Debounces raw keypad lines and decodes digit keys to 7-segment codes into an 8-slot working buffer; '#' advances the slot and '*' commits. A commit streams all 8 slots into the register file over its write port, one slot per cycle, then clears the buffer for the next entry.

---
 rtl/keypad_pkg.sv | 59 +++++
 rtl/keypad_entry_ctrl_key_debounce.sv | 79 +++++++
 rtl/keypad_entry_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared constants, types and segment decode
// for the keypad entry controller.
package keypad_pkg;

  localparam int SLOTS    = 8;
  localparam int KEYS     = 12;
  localparam int KEY_ZERO = 9;
  localparam int KEY_STAR = 10;
  localparam int KEY_HASH = 11;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b0000000;
  localparam seg_t SEG_0     = 7'b1111110;
  localparam seg_t SEG_1     = 7'b0110000;
  localparam seg_t SEG_2     = 7'b1101101;
  localparam seg_t SEG_3     = 7'b1111001;
  localparam seg_t SEG_4     = 7'b0110011;
  localparam seg_t SEG_5     = 7'b1011011;
  localparam seg_t SEG_6     = 7'b1011111;
  localparam seg_t SEG_7     = 7'b1110010;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1111011;

  typedef enum logic [1:0] {
    ENTRY,
    COMMIT,
    DONE
  } state_t;

  function automatic seg_t digit_to_seg(
    input logic [3:0] d
  );
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Key bits 0..8 are digits 1..9; bit 9 is digit 0.
  function automatic seg_t key_to_seg(
    input logic [3:0] idx
  );
    logic [3:0] d;
    d = (idx == 4'(KEY_ZERO)) ? 4'd0
                              : idx + 4'd1;
    return digit_to_seg(d);
  endfunction

endpackage

// File: rtl/keypad_entry_ctrl_key_debounce.sv
// Keypad line synchroniser and stability
// filter producing press and multi-hot pulses.
module key_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [KEYS-1:0] key_in,
  output logic [KEYS-1:0] accepted,
  output logic            press,
  output logic [3:0]      press_idx,
  output logic            err
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX =
    CW'(DEBOUNCE_CYCLES - 1);

  logic [KEYS-1:0] sync_q;
  logic [KEYS-1:0] acc_q;
  logic [CW-1:0]   cnt_q;
  logic            press_q;
  logic [3:0]      idx_q;
  logic            err_q;

  logic       stable;
  logic       take;
  logic [3:0] ones;
  logic [3:0] enc;

  always_comb begin
    ones = '0;
    enc  = '0;
    for (int i = 0; i < KEYS; i++) begin
      if (sync_q[i]) begin
        ones = ones + 4'd1;
        enc  = 4'(i);
      end
    end
  end

  // cnt_q counts repeats of sync_q, so at
  // CNT_MAX the last DEBOUNCE_CYCLES samples
  // all agree.
  assign stable = (cnt_q == CNT_MAX);
  assign take   = stable && (sync_q != acc_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      press_q <= 1'b0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      sync_q <= key_in;
      if (key_in != sync_q)
        cnt_q <= '0;
      else if (!stable)
        cnt_q <= cnt_q + 1'b1;
      press_q <= take && (acc_q == '0)
                      && (ones == 4'd1);
      err_q   <= take && (ones > 4'd1);
      if (take) begin
        acc_q <= sync_q;
        idx_q <= enc;
      end
    end
  end

  assign accepted  = acc_q;
  assign press     = press_q;
  assign press_idx = idx_q;
  assign err       = err_q;

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry sequencer: fills an 8-digit
// buffer and streams it to the register file.
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SLOTS           = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] key_in,
  output logic        rf_we,
  output logic [2:0]  rf_addr,
  output logic [6:0]  rf_wdata,
  output logic        busy,
  output logic [2:0]  cur_slot,
  output logic        commit_done,
  output logic        key_err
);

  logic [KEYS-1:0] key_state;
  logic            press;
  logic [3:0]      press_idx;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .accepted  (key_state),
    .press     (press),
    .press_idx (press_idx),
    .err       (key_err)
  );

  logic is_star;
  logic is_hash;
  logic is_digit;

  assign is_star  = key_state[KEY_STAR];
  assign is_hash  = key_state[KEY_HASH];
  assign is_digit = |key_state[KEY_ZERO:0];

  state_t     state_q, state_d;
  logic [2:0] wr_idx_q, wr_idx_d;
  logic [2:0] slot_q, slot_d;
  seg_t       buf_q [SLOTS];
  seg_t       buf_d [SLOTS];
  logic       we_q, we_d;
  logic [2:0] addr_q, addr_d;
  seg_t       wdata_q, wdata_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [2:0] nxt_idx;

  assign nxt_idx = wr_idx_q + 3'd1;

  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    slot_d   = slot_q;
    buf_d    = buf_q;
    we_d     = 1'b0;
    addr_d   = '0;
    wdata_d  = SEG_BLANK;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      ENTRY: begin
        if (press) begin
          unique case (1'b1)
            is_star: begin
              state_d  = COMMIT;
              wr_idx_d = '0;
              we_d     = 1'b1;
              wdata_d  = buf_q[0];
              busy_d   = 1'b1;
            end
            is_hash:
              slot_d = slot_q + 3'd1;
            is_digit:
              buf_d[slot_q] =
                key_to_seg(press_idx);
            default: ;
          endcase
        end
      end
      COMMIT: begin
        busy_d = 1'b1;
        if (wr_idx_q == 3'd7) begin
          state_d = DONE;
          done_d  = 1'b1;
          slot_d  = '0;
          for (int i = 0; i < SLOTS; i++)
            buf_d[i] = SEG_BLANK;
        end else begin
          wr_idx_d = nxt_idx;
          we_d     = 1'b1;
          addr_d   = nxt_idx;
          wdata_d  = buf_q[nxt_idx];
        end
      end
      DONE:
        state_d = ENTRY;
      default:
        state_d = ENTRY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ENTRY;
      wr_idx_q <= '0;
      slot_q   <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= SEG_BLANK;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < SLOTS; i++)
        buf_q[i] <= SEG_BLANK;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      slot_q   <= slot_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      for (int i = 0; i < SLOTS; i++)
        buf_q[i] <= buf_d[i];
    end
  end

  assign rf_we       = we_q;
  assign rf_addr     = addr_q;
  assign rf_wdata    = wdata_q;
  assign busy        = busy_q;
  assign cur_slot    = slot_q;
  assign commit_done = done_q;

endmodule
